// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit with architectural HI/LO.
//
// Performs MULTU/MULT/DIVU/DIV over WIDTH cycles (one shift-add or one
// restoring-subtract step per cycle). Products are written as {hi,lo};
// divides write the quotient to lo and the remainder to hi. mthi/mtlo
// write srca directly into HI/LO while the unit is idle.
//
// Configuration macro: MULDIV_SIGNED_EN
//   defined   -> op[0] selects signed MULT/DIV (magnitude arithmetic with
//                sign correction on the final edge)
//   undefined -> op[0] is ignored, every operation is unsigned
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   start    in   begin the operation selected by op (sampled in IDLE)
//   op       in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   srca     in   multiplicand / dividend / mthi-mtlo write data
//   srcb     in   multiplier / divisor
//   mthi     in   write srca into HI (IDLE only)
//   mtlo     in   write srca into LO (IDLE only)
//   flush    in   abort an operation in progress
//   stall    out  combinational pipeline stall request
//   busy     out  unit is iterating
//   done     out  one-cycle result-valid pulse
//   divzero  out  one-cycle pulse with done for a divide by zero
//   hi, lo   out  architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, stateNext;
    logic [CW-1:0]    count;
    logic             isDiv;
    logic             divZeroReg;
    logic [WIDTH-1:0] bMag, accHi, accLo, hiReg, loReg;
    logic [WIDTH-1:0] srcaMag, srcbMag;
    logic [WIDTH-1:0] stepHi, stepLo, resHi, resLo;
    logic [WIDTH:0]   mulSum, divTrial;
    logic             accept, zeroDiv, lastStep;

`ifdef MULDIV_SIGNED_EN
    logic             negA, negB;
    logic             srcaNeg, srcbNeg;
    logic [2*WIDTH-1:0] prodRes;

    assign srcaNeg = op[0] & srca[WIDTH-1];
    assign srcbNeg = op[0] & srcb[WIDTH-1];
    assign srcaMag = srcaNeg ? -srca : srca;
    assign srcbMag = srcbNeg ? -srcb : srcb;
`else
    logic unusedOpSign;

    assign unusedOpSign = op[0];
    assign srcaMag      = srca;
    assign srcbMag      = srcb;
`endif

    assign accept   = (state == IDLE) & start & ~flush & ~mthi & ~mtlo;
    assign zeroDiv  = op[1] & (srcb == '0);
    assign lastStep = (count == CW'(1));

    // One iteration step. Multiply: accHi:accLo shifts right with the
    // partial sum entering from the top. Divide: restoring division with
    // the remainder in accHi and the quotient shifting into accLo.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, bMag} : '0);
        divTrial = {accHi, accLo[WIDTH-1]} - {1'b0, bMag};
        if (isDiv) begin
            stepHi = divTrial[WIDTH] ? {accHi[WIDTH-2:0], accLo[WIDTH-1]}
                                     : divTrial[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], ~divTrial[WIDTH]};
        end else begin
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

    // Final result written on the last RUN edge, sign-corrected if enabled.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        prodRes = (negA ^ negB) ? -{stepHi, stepLo} : {stepHi, stepLo};
        if (isDiv) begin
            resLo = (negA ^ negB) ? -stepLo : stepLo;
            resHi = negA ? -stepHi : stepHi;
        end else begin
            resHi = prodRes[2*WIDTH-1:WIDTH];
            resLo = prodRes[WIDTH-1:0];
        end
`else
        resHi = stepHi;
        resLo = stepLo;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = zeroDiv ? DONE : RUN;
            RUN: begin
                if (flush)         stateNext = IDLE;
                else if (lastStep) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy    = (state == RUN);
        done    = (state == DONE);
        divzero = (state == DONE) & divZeroReg;
        stall   = accept | (state == RUN);
        hi      = hiReg;
        lo      = loReg;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            isDiv      <= 1'b0;
            divZeroReg <= 1'b0;
            bMag       <= '0;
            accHi      <= '0;
            accLo      <= '0;
            hiReg      <= '0;
            loReg      <= '0;
`ifdef MULDIV_SIGNED_EN
            negA       <= 1'b0;
            negB       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mthi) hiReg <= srca;
                    if (mtlo) loReg <= srca;
                    if (accept) begin
                        count      <= CW'(WIDTH);
                        isDiv      <= op[1];
                        divZeroReg <= zeroDiv;
                        accHi      <= '0;
                        accLo      <= srcaMag;
                        bMag       <= srcbMag;
`ifdef MULDIV_SIGNED_EN
                        negA       <= srcaNeg;
                        negB       <= srcbNeg;
`endif
                    end
                end
                RUN: begin
                    if (flush) begin
                        count <= '0;
                    end else begin
                        accHi <= stepHi;
                        accLo <= stepLo;
                        count <= count - CW'(1);
                        if (lastStep) begin
                            hiReg <= resHi;
                            loReg <= resLo;
                        end
                    end
                end
                DONE: begin
                    count      <= '0;
                    divZeroReg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED = 1'b1;
`else
    localparam bit SIGNED = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, mthi, mtlo, flush;
    logic [1:0]   op;
    logic [W-1:0] srca, srcb;
    logic         stall, busy, done, divzero;
    logic [W-1:0] hi, lo;

    int nAssert = 0;
    int nFail   = 0;
    logic [W-1:0] mHi = '0;
    logic [W-1:0] mLo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .mthi(mthi), .mtlo(mtlo), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .divzero(divzero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nAssert++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain 64-bit arithmetic on (sign- or zero-) extended operands.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, p, q, r;
        if (SIGNED && o[0]) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
        end
        if (!o[1]) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic runOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit flushAtDone);
        logic [63:0] expv;
        logic dz;
        int busyN, stallN, doneN, doneAt;
        logic dzSeen;
        logic [W-1:0] hiSeen, loSeen;
        dz = o[1] && (b == '0);
        expv = dz ? {mHi, mLo} : model(o, a, b);
        busyN = 0; stallN = 0; doneN = 0; doneAt = 0;
        dzSeen = 1'b0; hiSeen = '0; loSeen = '0;
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        #1 check("stall_on_start", stall, 1);
        @(negedge clk);
        // Noise while the operation runs: start/mthi/mtlo must be ignored.
        start = 1'b1; srca = $urandom; srcb = $urandom; mthi = 1'b1; mtlo = 1'b1;
        #1;
        for (int c = 1; c <= W + 3; c++) begin
            if (busy) busyN++;
            if (stall) stallN++;
            if (done) begin
                doneN++;
                if (doneAt == 0) begin
                    doneAt = c; dzSeen = divzero; hiSeen = hi; loSeen = lo;
                    if (flushAtDone) flush = 1'b1;
                end
            end
            @(negedge clk);
            mthi = 1'b0; mtlo = 1'b0; flush = 1'b0; start = 1'b0;
            #1;
        end
        check("busy_cycles", busyN, dz ? 0 : W);
        check("stall_cycles", stallN, dz ? 0 : W);
        check("done_count", doneN, 1);
        check("done_cycle", doneAt, dz ? 1 : W + 1);
        check("divzero", dzSeen, dz);
        check("hi_at_done", hiSeen, expv[63:32]);
        check("lo_at_done", loSeen, expv[31:0]);
        check("hi_hold", hi, expv[63:32]);
        check("lo_hold", lo, expv[31:0]);
        mHi = expv[63:32];
        mLo = expv[31:0];
    endtask

    task automatic writeHiLo(input logic wh, input logic wl, input logic [W-1:0] d, input logic st);
        @(negedge clk);
        mthi = wh; mtlo = wl; srca = d; start = st; op = 2'b00; srcb = 32'd3;
        #1 check("stall_with_mtx", stall, 0);
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
        #1;
        if (wh) mHi = d;
        if (wl) mLo = d;
        check("mtx_hi", hi, mHi);
        check("mtx_lo", lo, mLo);
        check("mtx_no_busy", busy, 0);
    endtask

    initial begin
        logic [W-1:0] corner [5];
        logic [1:0] ro;
        logic [W-1:0] ra, rb;
        int doneN;
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF;

        reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        op = 2'b00; srca = '0; srcb = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_divzero", divzero, 0);
        check("rst_stall", stall, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        start = 1'b1;
        #1 check("rst_stall_start", stall, 1);
        @(negedge clk); @(negedge clk);
        start = 1'b0; reset = 1'b1;

        // Directed vectors
        runOp(2'b00, 32'hFFFFFFFF, 32'h2, 1'b0);
        check("multu_hi", hi, 32'h1);
        check("multu_lo", lo, 32'hFFFFFFFE);
        runOp(2'b01, 32'hFFFFFFFD, 32'h5, 1'b0);
        check("mult_hi", hi, SIGNED ? 32'hFFFFFFFF : 32'h4);
        check("mult_lo", lo, 32'hFFFFFFF1);
        runOp(2'b11, 32'hFFFFFFF9, 32'h2, 1'b1);
        check("div_lo", lo, SIGNED ? 32'hFFFFFFFD : 32'h7FFFFFFC);
        check("div_hi", hi, SIGNED ? 32'hFFFFFFFF : 32'h1);
        runOp(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("divovf_lo", lo, SIGNED ? 32'h80000000 : 32'h0);
        check("divovf_hi", hi, SIGNED ? 32'h0 : 32'h80000000);

        // mthi/mtlo, including one that overrides a start
        writeHiLo(1'b1, 1'b0, 32'h12345678, 1'b0);
        runOp(2'b10, 32'd10, 32'd0, 1'b1);
        check("dz_hi_kept", hi, 32'h12345678);
        writeHiLo(1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
        writeHiLo(1'b0, 1'b1, 32'h0BADBEEF, 1'b1);

        // flush in IDLE suppresses start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; srca = 32'd7; srcb = 32'd9;
        #1 check("flush_idle_stall", stall, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 check("flush_idle_busy", busy, 0);

        // flush in RUN: start in cycle 0, flush in cycle 10
        @(negedge clk);
        start = 1'b1; op = 2'b00; srca = 32'h11111111; srcb = 32'h22222222;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 check("flush_run_busy_before", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 check("flush_run_busy_after", busy, 0);
        doneN = 0;
        for (int c = 0; c < W + 3; c++) begin
            if (done) doneN++;
            @(negedge clk);
        end
        check("flush_no_done", doneN, 0);
        check("flush_hi", hi, mHi);
        check("flush_lo", lo, mLo);

        // reset pulse in cycle 5 of a run
        @(negedge clk);
        start = 1'b1; op = 2'b10; srca = 32'h99999999; srcb = 32'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 check("rstrun_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("rstrun_busy", busy, 0);
        check("rstrun_hi", hi, 0);
        check("rstrun_lo", lo, 0);
        mHi = '0; mLo = '0;
        @(negedge clk);
        reset = 1'b1;
        doneN = 0;
        for (int c = 0; c < W + 3; c++) begin
            if (done) doneN++;
            @(negedge clk);
        end
        check("rstrun_no_done", doneN, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = corner[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) rb = corner[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) rb = '0;
            runOp(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
